// File: rtl/tqvp_stevej_wdt_escalator.sv
// Watchdog escalator: turns a watchdog expiry into a bark interrupt with a grace
// period, then a fixed-length active-low reset pulse if the bark is not acknowledged.
module tqvp_stevej_wdt_escalator #(
  parameter int unsigned PULSE_CYCLES = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdt_expired,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic        sys_reset_n,
  output logic [7:0]  uo_out
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES) + 1;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_GRACE  = 6'h04;
  localparam logic [5:0] ADDR_ACK    = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_CLRCNT = 6'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BARK    = 2'd1,
    BITE    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              enable, lock;
  logic [31:0]       grace, grace_cnt;
  logic [PW-1:0]     pulse_cnt;
  logic [CNT_W-1:0]  bite_count;

  logic              wr_en, ack;
  logic [31:0]       wr_mask;
  logic              unused_rd;

  assign wr_en      = (data_write_n != 2'b11);
  assign ack        = wr_en && (address == ADDR_ACK);
  assign data_ready = 1'b1;
  assign unused_rd  = &{1'b0, data_read_n};

  // Byte lanes touched by a write of the given width.
  always_comb begin
    wr_mask = 32'hFFFF_FFFF;
    case (data_write_n)
      2'b00:   wr_mask = 32'h0000_00FF;
      2'b01:   wr_mask = 32'h0000_FFFF;
      default: wr_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Escalation next-state; BARK exits are prioritised ack, disable, then grace expiry.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable && wdt_expired) state_n = BARK;
      BARK: begin
        if (ack || !enable)          state_n = IDLE;
        else if (grace_cnt == 32'd0) state_n = BITE;
      end
      BITE:    if (pulse_cnt == '0) state_n = HOLDOFF;
      HOLDOFF: if (!wdt_expired) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      enable         <= 1'b0;
      lock           <= 1'b0;
      grace          <= 32'd0;
      grace_cnt      <= 32'd0;
      pulse_cnt      <= '0;
      bite_count     <= '0;
      user_interrupt <= 1'b0;
      sys_reset_n    <= 1'b1;
      uo_out         <= 8'b1000_0000;
    end else begin
      state          <= state_n;
      user_interrupt <= (state_n == BARK);
      sys_reset_n    <= (state_n != BITE);
      uo_out         <= {state_n != BITE, state_n == BARK, state_n, 4'b0000};

      case (state)
        IDLE: if (state_n == BARK) grace_cnt <= grace;
        BARK: begin
          if (state_n == BITE) begin
            pulse_cnt <= PW'(PULSE_CYCLES - 1);
            if (bite_count != '1) bite_count <= bite_count + CNT_W'(1);
          end else if (state_n == BARK) begin
            grace_cnt <= grace_cnt - 32'd1;
          end
        end
        BITE: if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - PW'(1);
        default: ;
      endcase

      // Configuration writes; a counter clear overrides a same-cycle bite increment.
      if (wr_en && !lock) begin
        if (address == ADDR_CTRL) begin
          enable <= data_in[0];
          lock   <= data_in[1];
        end
        if (address == ADDR_GRACE) grace <= (grace & ~wr_mask) | (data_in & wr_mask);
        if (address == ADDR_CLRCNT && data_in[0]) bite_count <= '0;
      end
    end
  end

  // Register read mux.
  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_CTRL:   data_out = {30'd0, lock, enable};
      ADDR_GRACE:  data_out = grace;
      ADDR_STATUS: data_out = {16'd0, 8'(bite_count), 5'd0, wdt_expired, state};
      default:     data_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Self-checking bench for the watchdog escalator: register vector table, directed
// escalation sequences, and randomized traffic against a cycle-level reference model.
module tb_tqvp_stevej_wdt_escalator;

  localparam int PULSE = 64;

  logic        clk;
  logic        rst_n;
  logic        wdt_expired;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic        sys_reset_n;
  logic [7:0]  uo_out;

  int checks = 0;
  int errors = 0;

  tqvp_stevej_wdt_escalator #(.PULSE_CYCLES(PULSE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wdt_expired(wdt_expired), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt),
    .sys_reset_n(sys_reset_n), .uo_out(uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Advance one edge, then check the interrupt/reset exclusivity on the visible state.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if ((user_interrupt && uo_out[5:4] != 2'd1) || (!sys_reset_n && uo_out[5:4] != 2'd2) ||
        (user_interrupt && !sys_reset_n)) begin
      errors++;
      $display("FAIL invariant actual=ui%0b srn%0b st%0d required=consistent",
               user_interrupt, sys_reset_n, uo_out[5:4]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wdt_expired = 1'b0; data_write_n = 2'b11; address = 6'h00; data_in = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a; data_write_n = 2'b11;
    #1;
    d = data_out;
  endtask

  task automatic pulse_exp();
    wdt_expired = 1'b1;
    tick();
    wdt_expired = 1'b0;
  endtask

  task automatic run_count(input int n, output int uis, output int bites);
    uis = 0; bites = 0;
    for (int i = 0; i < n; i++) begin
      if (user_interrupt) uis++;
      if (!sys_reset_n) bites++;
      tick();
    end
  endtask

  // Reference model: escalation expressed as phase plus cycles remaining in that phase.
  int          m_st, m_cnt, m_bleft;
  bit          m_en, m_lock;
  logic [31:0] m_grace;
  longint      m_gleft;

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_bleft = 0; m_en = 0; m_lock = 0; m_grace = '0; m_gleft = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a, input bit e);
    case (a)
      6'h00:   return {30'd0, m_lock, m_en};
      6'h04:   return m_grace;
      6'h0C:   return (32'(m_cnt) << 8) | (32'(e) << 2) | 32'(m_st);
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input bit e, input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    bit          w;
    logic [31:0] mask;
    w = (wn != 2'b11);
    mask = (wn == 2'b00) ? 32'hFF : (wn == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    case (m_st)
      0: if (m_en && e) begin m_st = 1; m_gleft = longint'(m_grace); end
      1: begin
        if ((w && a == 6'h08) || !m_en) m_st = 0;
        else if (m_gleft == 0) begin
          m_st = 2; m_bleft = PULSE;
          if (m_cnt < 255) m_cnt++;
        end else m_gleft--;
      end
      2: begin m_bleft--; if (m_bleft == 0) m_st = 3; end
      default: if (!e) m_st = 0;
    endcase
    if (w && !m_lock) begin
      if (a == 6'h00) begin m_en = d[0]; m_lock = d[1]; end
      if (a == 6'h04) m_grace = (m_grace & ~mask) | (d & mask);
      if (a == 6'h10 && d[0]) m_cnt = 0;
    end
  endtask

  typedef struct {
    logic [1:0]  wn;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] d;
    int          u, b;
    bit          e;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [1:0]  wn;

    data_read_n = 2'b11;
    do_reset();

    // Reset state
    chk("rst_ui", 32'(user_interrupt), 32'd0);
    chk("rst_srn", 32'(sys_reset_n), 32'd1);
    chk("rst_uo", 32'(uo_out), 32'h80);
    chk("rst_ready", 32'(data_ready), 32'd1);
    rd(6'h00, d); chk("rst_ctrl", d, 32'd0);
    rd(6'h04, d); chk("rst_grace", d, 32'd0);
    rd(6'h0C, d); chk("rst_status", d, 32'd0);

    // Register access vectors (wdt_expired low, so no escalation)
    vecs[0] = '{2'b10, 6'h04, 32'h1234_5678, 32'h1234_5678};
    vecs[1] = '{2'b00, 6'h04, 32'hFFFF_FFAB, 32'h1234_56AB};
    vecs[2] = '{2'b01, 6'h04, 32'hAAAA_C0DE, 32'h1234_C0DE};
    vecs[3] = '{2'b11, 6'h04, 32'h0000_0000, 32'h1234_C0DE};
    vecs[4] = '{2'b10, 6'h00, 32'hFFFF_FFFD, 32'h0000_0001};
    vecs[5] = '{2'b10, 6'h14, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{2'b10, 6'h0C, 32'h0000_00FF, 32'h0000_0000};
    vecs[7] = '{2'b10, 6'h08, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{2'b00, 6'h00, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{2'b10, 6'h3C, 32'h1111_1111, 32'h0000_0000};
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].wdata, vecs[i].wn);
      rd(vecs[i].addr, d);
      chk($sformatf("vec%0d", i), d, vecs[i].exp_rd);
    end

    // GRACE=10, one-cycle expiry: 11 bark cycles, 64 bite cycles, back to IDLE
    do_reset();
    wr(6'h00, 32'd1, 2'b10); wr(6'h04, 32'd10, 2'b10);
    pulse_exp();
    run_count(100, u, b);
    chk("a_bark_len", 32'(u), 32'd11);
    chk("a_bite_len", 32'(b), 32'(PULSE));
    rd(6'h0C, d);
    chk("a_count", 32'(d[15:8]), 32'd1);
    chk("a_state", 32'(d[1:0]), 32'd0);

    // ACK on the 5th bark cycle
    do_reset();
    wr(6'h00, 32'd1, 2'b10); wr(6'h04, 32'd10, 2'b10);
    pulse_exp();
    for (int i = 0; i < 4; i++) tick();
    chk("b_in_bark", 32'(user_interrupt), 32'd1);
    wr(6'h08, 32'd0, 2'b10);
    chk("b_ui_drop", 32'(user_interrupt), 32'd0);
    run_count(80, u, b);
    chk("b_no_bite", 32'(b), 32'd0);
    rd(6'h0C, d);
    chk("b_count", 32'(d[15:8]), 32'd0);

    // GRACE=0 with expiry held high: holdoff until it falls, no re-bark
    do_reset();
    wr(6'h00, 32'd1, 2'b10); wr(6'h04, 32'd0, 2'b10);
    wdt_expired = 1'b1;
    tick();
    run_count(65, u, b);
    chk("c_bark_len", 32'(u), 32'd1);
    chk("c_bite_len", 32'(b), 32'(PULSE));
    run_count(20, u, b);
    chk("c_hold_quiet", 32'(u + b), 32'd0);
    rd(6'h0C, d);
    chk("c_holdoff", 32'(d[2:0]), 32'd7);
    wdt_expired = 1'b0;
    tick();
    rd(6'h0C, d);
    chk("c_idle", 32'(d[1:0]), 32'd0);
    run_count(10, u, b);
    chk("c_no_rebark", 32'(u), 32'd0);

    // Lock: later CTRL/GRACE/CLRCNT writes ignored, escalation still works
    do_reset();
    wr(6'h04, 32'd2, 2'b10); wr(6'h00, 32'd1, 2'b10);
    pulse_exp();
    run_count(80, u, b);
    chk("d_first_bite", 32'(b), 32'(PULSE));
    wr(6'h00, 32'd3, 2'b10);
    wr(6'h00, 32'd0, 2'b10);
    wr(6'h04, 32'd5, 2'b10);
    wr(6'h10, 32'd1, 2'b10);
    rd(6'h00, d); chk("d_ctrl", d, 32'd3);
    rd(6'h04, d); chk("d_grace", d, 32'd2);
    rd(6'h0C, d); chk("d_count1", 32'(d[15:8]), 32'd1);
    pulse_exp();
    run_count(80, u, b);
    chk("d_bark_len", 32'(u), 32'd3);
    chk("d_bite_len", 32'(b), 32'(PULSE));
    rd(6'h0C, d); chk("d_count2", 32'(d[15:8]), 32'd2);

    // ACK coincident with grace expiry wins
    do_reset();
    wr(6'h00, 32'd1, 2'b10); wr(6'h04, 32'd3, 2'b10);
    pulse_exp();
    for (int i = 0; i < 3; i++) tick();
    wr(6'h08, 32'd0, 2'b00);
    rd(6'h0C, d); chk("f_state", 32'(d[1:0]), 32'd0);
    run_count(80, u, b);
    chk("f_no_bite", 32'(b), 32'd0);

    // Counter saturation over 256 bites, then reset mid-bite
    do_reset();
    wr(6'h00, 32'd1, 2'b10); wr(6'h04, 32'd0, 2'b10);
    for (int k = 0; k < 256; k++) begin
      pulse_exp();
      run_count(68, u, b);
    end
    rd(6'h0C, d); chk("e_saturate", 32'(d[15:8]), 32'd255);
    pulse_exp();
    tick(); tick();
    chk("e_mid_bite", 32'(sys_reset_n), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("e_rst_srn", 32'(sys_reset_n), 32'd1);
    chk("e_rst_uo", 32'(uo_out), 32'h80);
    rd(6'h0C, d); chk("e_rst_status", d, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    e = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) e = ~e;
      case ($urandom_range(0, 5))
        0: a = 6'h00;
        1: a = 6'h04;
        2: a = 6'h08;
        3: a = 6'h0C;
        4: a = 6'h10;
        default: a = 6'($urandom_range(0, 63));
      endcase
      wn = 2'b11;
      if ($urandom_range(0, 5) == 0) wn = 2'($urandom_range(0, 2));
      if (a == 6'h00)      wd = {30'd0, $urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0};
      else if (a == 6'h04) wd = 32'($urandom_range(0, 40));
      else                 wd = $urandom;
      wdt_expired = e; address = a; data_in = wd; data_write_n = wn;
      #1;
      chk("rnd_rd", data_out, m_read(a, e));
      tick();
      m_step(e, a, wd, wn);
      chk("rnd_ui", 32'(user_interrupt), 32'(m_st == 1));
      chk("rnd_srn", 32'(sys_reset_n), 32'(m_st != 2));
      chk("rnd_uo", 32'(uo_out), {24'd0, m_st != 2, m_st == 1, 2'(m_st), 4'b0000});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
